add_32bit_seq: RTL and testbench
================================

ADD_32BIT_SEQ -- requirements
Module: add_32bit_seq

Interface
REQ-001 Parameters: none; the datapath SHALL be fixed at 32 bits, processed 8 bits per cycle.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands a/b valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  addend A, two's complement.
REQ-007 b  input  32  addend B, two's complement.
REQ-008 out_valid  output  1  sum/overflow valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 sum  output  32  registered a+b, modulo 2^32 (or saturated per REQ-031).
REQ-011 overflow  output  1  signed overflow of the accepted operation.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept = in_valid & in_ready at a rising edge; the block SHALL then register a and b, clear the carry, set the byte index to 0 and enter CALC.
REQ-016 Each CALC cycle SHALL add byte k of both operands plus the carry, write sum[8k+7:8k], store the carry-out and increment k.
REQ-017 After the edge that processes byte 3, the FSM SHALL enter DONE: out_valid is first high after the 4th rising edge following the accept edge.
REQ-018 overflow SHALL equal (a[31]==b[31]) & (raw_sum[31]!=a[31]); the final carry-out SHALL be discarded.
REQ-019 In DONE, sum and overflow SHALL hold stable until out_valid & out_ready; the FSM then returns to IDLE on that edge.
REQ-020 out_valid & out_ready SHALL NOT also accept new operands on the same edge; in_ready rises one cycle later.
REQ-021 in_valid in CALC/DONE SHALL be ignored; a and b changing after accept SHALL NOT affect the result.
REQ-022 sum/overflow SHALL retain the last completed result in IDLE and update only in CALC.
REQ-023 Byte index SHALL be 2 bits and wrap 3->0 exactly on the CALC->DONE transition.
REQ-024 Carry SHALL propagate across all byte boundaries (e.g. 0xFFFFFFFF+1 ripples through all 4 bytes).

Reset
REQ-025 rst high at a rising edge SHALL force IDLE and take priority over every other event, including accept and handshake completion.
REQ-026 Reset values: in_ready=1 (after reset released, state IDLE), out_valid=0, busy=0, sum=0, overflow=0; carry and byte index cleared.
REQ-027 Reset during CALC or DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-028 Macro ADD_SAT_EN SHALL select saturating output.
REQ-029 Without ADD_SAT_EN: sum SHALL be the raw modulo-2^32 result.
REQ-030 With ADD_SAT_EN: overflow SHALL still report per REQ-018, computed from the raw sum.
REQ-031 With ADD_SAT_EN and overflow=1: sum SHALL be 0x7FFFFFFF if a[31]=0, else 0x80000000, applied when entering DONE; latency unchanged.

Verification
REQ-032 a=5, b=3, accept at edge E0, out_ready=1 -> out_valid high after E4, sum=0x00000008, overflow=0, IDLE after E5.
REQ-033 a=0x7FFFFFFF, b=0x00000001 -> overflow=1; sum=0x80000000 (no macro) / 0x7FFFFFFF (ADD_SAT_EN).
REQ-034 a=0x80000000, b=0x80000000 -> overflow=1; sum=0x00000000 (no macro) / 0x80000000 (ADD_SAT_EN).
REQ-035 a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, overflow=0 (full carry ripple, no signed overflow).
REQ-036 out_ready held 0 for 3 cycles in DONE, in_valid=1 with new operands -> sum/overflow stable, in_ready=0, new operands ignored; handshake then IDLE.
REQ-037 rst pulsed on the 2nd CALC cycle -> next cycle IDLE, in_ready=1, sum=0, overflow=0, out_valid never asserted.

Source files
------------

// File: rtl/add_32bit_seq_if.sv
// Operand/result handshake bundle for add_32bit_seq.
// The slave modport is the adder's view and the master modport is the driver/consumer's view.
interface add_32bit_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        overflow;
   logic        busy;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, overflow, busy
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, overflow, busy
   );
endinterface

// File: rtl/add_32bit_seq.sv
// Byte-serial 32-bit two's-complement adder (8 bits per cycle) with valid/ready handshake.
// Optional macro ADD_SAT_EN: saturate the sum on signed overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high, last result held
// CALC  | one byte per cycle, carry rippling upward
// DONE  | result valid, held until out_ready
module add_32bit_seq (
   input  logic            clk,
   input  logic            rst,
   add_32bit_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q;
   logic [31:0] a_q, b_q, sum_q;
   logic        carry_q, overflow_q;
   logic [1:0]  idx_q;
   logic        in_ready_q, out_valid_q, busy_q;

   logic [7:0]  a_byte, b_byte;
   logic [8:0]  byte_sum_d;
   logic        ovf_d;
   logic [31:0] sat_d;

   always_comb begin
      a_byte     = a_q[{idx_q, 3'b000} +: 8];
      b_byte     = b_q[{idx_q, 3'b000} +: 8];
      byte_sum_d = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
      // byte_sum_d[7] is bit 31 of the raw sum when the top byte is in flight
      ovf_d      = (a_q[31] == b_q[31]) & (byte_sum_d[7] != a_q[31]);
      sat_d      = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         idx_q       <= 2'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  carry_q    <= 1'b0;
                  idx_q      <= 2'd0;
                  state_q    <= CALC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            CALC: begin
               sum_q[{idx_q, 3'b000} +: 8] <= byte_sum_d[7:0];
               carry_q <= byte_sum_d[8];
               idx_q   <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  overflow_q  <= ovf_d;
`ifdef ADD_SAT_EN
                  if (ovf_d) begin
                     sum_q <= sat_d;
                  end
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef ADD_SAT_EN
   logic unused_sat;
   assign unused_sat = ^sat_d;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_add_32bit_seq.sv
// Self-checking bench for add_32bit_seq: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_add_32bit_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   add_32bit_seq_if bus ();
   add_32bit_seq dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // returns {overflow, sum} computed with wide signed arithmetic
   function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
      longint     s;
      logic       ovf;
      logic [31:0] r;
      s   = longint'($signed(x)) + longint'($signed(y));
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r   = x + y;
`ifdef ADD_SAT_EN
      if (ovf) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {ovf, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                         input bit keep_valid, input string name);
      logic [32:0] exp;
      exp = model(av, bv);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s idle_ready got %b want 1", name, bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.a = av; bus.b = bv;
      tick();
      bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL %s accept busy=%b ready=%b want 1/0", name, bus.busy, bus.in_ready);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s early_valid cycle %0d got %b want 0", name, i, bus.out_valid);
         end
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== exp[31:0] || bus.overflow !== exp[32]) begin
         n_fail++;
         $display("FAIL %s result valid=%b sum=%h ovf=%b want 1 %h %b",
                  name, bus.out_valid, bus.sum, bus.overflow, exp[31:0], exp[32]);
      end
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             bus.sum !== exp[31:0] || bus.overflow !== exp[32]) begin
            n_fail++;
            $display("FAIL %s hold%0d valid=%b ready=%b sum=%h ovf=%b want 1 0 %h %b",
                     name, i, bus.out_valid, bus.in_ready, bus.sum, bus.overflow, exp[31:0], exp[32]);
         end
      end
      bus.in_valid  = keep_valid;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.sum !== exp[31:0] || bus.overflow !== exp[32]) begin
         n_fail++;
         $display("FAIL %s handshake valid=%b ready=%b busy=%b sum=%h ovf=%b want 0 1 0 %h %b",
                  name, bus.out_valid, bus.in_ready, bus.busy, bus.sum, bus.overflow, exp[31:0], exp[32]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1;
      tick(); tick();
      rst = 1'b0; bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.sum !== 32'h0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset ready=%b valid=%b busy=%b sum=%h ovf=%b want 1 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.overflow);
      end
   endtask

   task automatic test_directed();
      run_op(32'd5, 32'd3, 0, 1'b0, "five_plus_three");
      run_op(32'h7FFF_FFFF, 32'h1, 1, 1'b0, "pos_overflow");
      run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b0, "neg_overflow");
      run_op(32'hFFFF_FFFF, 32'h1, 0, 1'b0, "carry_ripple");
      run_op(32'h00FF_00FF, 32'h0001_0001, 0, 1'b0, "partial_carry");
   endtask

   task automatic test_stall();
      run_op(32'h1357_9BDF, 32'h2468_ACE0, 3, 1'b0, "stall3");
   endtask

   task automatic test_back_to_back();
      run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 1'b1, "b2b_first");
      run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1'b1, "b2b_second");
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 1'b1; bus.a = 32'h7FFF_FFFF; bus.b = 32'h7FFF_FFFF;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sum !== 32'h0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_calc ready=%b busy=%b sum=%h ovf=%b want 1 0 0 0",
                  bus.in_ready, bus.busy, bus.sum, bus.overflow);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_calc_novalid cycle %0d got %b want 0", i, bus.out_valid);
         end
      end
      // reset in DONE beats a simultaneous handshake and a pending accept
      bus.in_valid = 1'b1; bus.a = 32'h1; bus.b = 32'h2;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      tick();
      rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.sum !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_done valid=%b ready=%b busy=%b sum=%h want 0 1 0 0",
                  bus.out_valid, bus.in_ready, bus.busy, bus.sum);
      end
   endtask

   task automatic test_random();
      logic [31:0] av, bv;
      for (int i = 0; i < 25; i++) begin
         av = $urandom;
         bv = $urandom;
         if (i % 5 == 0) av = {av[31], 31'h7FFF_FFFF};
         if (i % 5 == 1) bv = ~av + 32'd1;
         run_op(av, bv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
